// File: rtl/y1_0_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : y1_0_pattern_gen
// Purpose  : Burst stimulus source for the y1_0 word detector; counts flag
//            disagreements against the expected match result.
// Revision : 1.0  initial release
// ============================================================================
module y1_0_pattern_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic [3:0]  len,
  input  logic        ready,
  input  logic        match_in,
  output logic [15:0] po_word,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_cnt
);

  localparam logic [15:0] C_GOLDEN  = 16'h462C;
  localparam logic [15:0] C_ILLEGAL = 16'h462F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic [4:0]  rem_q, rem_d;
  logic [1:0]  k3_q, k3_d;
  logic [3:0]  k15_q, k15_d;
  logic [7:0]  err_q, err_d;
  logic [15:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] w_word;

  // k is tracked as two residues so no divider is needed for k mod 3 / k mod 15
  always_comb begin
    w_word = C_GOLDEN | {14'd0, k3_d};
    if (mode_d) begin
      if (k15_d == 4'd14) w_word = C_ILLEGAL;
      else                w_word = C_GOLDEN ^ (16'h0001 << (k15_d + 4'd2));
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    k3_d    = k3_q;
    k15_d   = k15_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          rem_d   = (len == 4'd0) ? 5'd16 : {1'b0, len};
          k3_d    = 2'd0;
          k15_d   = 4'd0;
          err_d   = 8'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (valid_q && ready) begin
          if ((match_in == mode_q) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
          k3_d  = (k3_q == 2'd2) ? 2'd0 : k3_q + 2'd1;
          k15_d = (k15_q == 4'd14) ? 4'd0 : k15_q + 4'd1;
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    word_d  = valid_d ? w_word : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      rem_q   <= 5'd0;
      k3_q    <= 2'd0;
      k15_q   <= 4'd0;
      err_q   <= 8'd0;
      word_q  <= 16'h0000;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      k3_q    <= k3_d;
      k15_q   <= k15_d;
      err_q   <= err_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign po_word = word_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err_cnt = err_q;

endmodule
`default_nettype wire

// File: tb/tb_y1_0_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_y1_0_pattern_gen
// Purpose  : Scoreboard bench for y1_0_pattern_gen with a detector model.
// Revision : 1.0  initial release
// ============================================================================
module tb_y1_0_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  len = 4'd0;
  logic        ready = 1'b0;
  logic        match_in;
  logic [15:0] po_word;
  logic        valid, busy, done;
  logic [7:0]  err_cnt;

  int          msel = 0;   // 0 ideal, 1 tied 0, 2 tied 1, 3 inverted
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  logic        ideal;

  always #5 clk = ~clk;

  y1_0_pattern_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .len(len),
    .ready(ready), .match_in(match_in), .po_word(po_word), .valid(valid),
    .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  assign ideal = (po_word[15:2] == 14'h118B) && (po_word[1:0] != 2'b11);
  always_comb begin
    case (msel)
      1:       match_in = 1'b0;
      2:       match_in = 1'b1;
      3:       match_in = ~ideal;
      default: match_in = ideal;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input bit m, input int k);
    int j;
    if (!m) return 16'h462C | 16'(k % 3);
    j = k % 15;
    if (j == 14) return 16'h462F;
    return 16'h462C ^ (16'h0001 << (j + 2));
  endfunction

  task automatic run_burst(input bit m, input logic [3:0] l, input int sel,
                           input bit stall, input bit prev_err_chk);
    int          L, c, hs, dones, done_c, exp_err;
    bit          held;
    logic [15:0] held_word;
    L = (l == 4'd0) ? 16 : int'(l);
    case (sel)
      1:       exp_err = m ? 0 : L;
      2:       exp_err = m ? L : 0;
      3:       exp_err = L;
      default: exp_err = 0;
    endcase
    if (exp_err > 255) exp_err = 255;
    @(negedge clk);
    if (prev_err_chk) check_val("err_hold_idle", {24'd0, err_cnt}, 32'(err_cnt));
    start = 1'b1; mode = m; len = l; msel = sel; ready = 1'b1;
    for (int k = 0; k < L; k++) exp_q.push_back(exp_word(m, k));
    @(negedge clk);
    start = 1'b0; mode = ~m; len = 4'($urandom_range(1, 15));
    check_val("busy_first", {31'd0, busy}, 32'd1);
    check_val("err_cleared", {24'd0, err_cnt}, 32'd0);
    c = 1; hs = 0; dones = 0; done_c = 0; held = 1'b0; held_word = 16'h0;
    while (c < 400) begin
      if (done) begin
        dones++; done_c = c; start = 1'b0;
        check_val("valid_in_done", {31'd0, valid}, 32'd0);
        break;
      end
      ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      start = stall ? 1'($urandom_range(0, 1)) : 1'b0;
      if (held) check_val("stall_stable", {16'd0, po_word}, {16'd0, held_word});
      if (valid && ready) begin
        if (exp_q.size() == 0) check_val("sb_underflow", 32'd1, 32'd0);
        else check_val("word", {16'd0, po_word}, {16'd0, exp_q.pop_front()});
        hs++;
      end
      held = valid && !ready;
      held_word = po_word;
      @(negedge clk);
      c++;
    end
    if (c >= 400) check_val("timeout", 32'(c), 32'd0);
    check_val("handshakes", 32'(hs), 32'(L));
    check_val("done_pulses", 32'(dones), 32'd1);
    if (!stall) check_val("done_cycle", 32'(done_c), 32'(L + 1));
    check_val("err_cnt", {24'd0, err_cnt}, 32'(exp_err));
    @(negedge clk);
    check_val("idle_busy", {31'd0, busy}, 32'd0);
    check_val("idle_done", {31'd0, done}, 32'd0);
    check_val("idle_word", {16'd0, po_word}, 32'd0);
    check_val("err_hold", {24'd0, err_cnt}, 32'(exp_err));
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_word", {16'd0, po_word}, 32'd0);
    check_val("rst_flags", {29'd0, valid, busy, done}, 32'd0);
    check_val("rst_err", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_burst(1'b0, 4'd4, 0, 1'b0, 1'b0);
    run_burst(1'b1, 4'd0, 0, 1'b0, 1'b0);
    run_burst(1'b0, 4'd3, 1, 1'b0, 1'b0);
    run_burst(1'b1, 4'd2, 2, 1'b0, 1'b1);
    run_burst(1'b0, 4'd5, 0, 1'b1, 1'b0);
    // back-to-back full-length bursts with every flag wrong (~300 words)
    for (int b = 0; b < 19; b++) run_burst(1'(b % 2), 4'd0, 3, 1'b0, 1'b0);

    // asynchronous abort in the middle of a burst
    @(negedge clk);
    start = 1'b1; mode = 1'b0; len = 4'd8; msel = 1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("pre_abort_err", {24'd0, err_cnt}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_word", {16'd0, po_word}, 32'd0);
    check_val("abort_flags", {29'd0, valid, busy, done}, 32'd0);
    check_val("abort_err", {24'd0, err_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    check_val("abort_no_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    run_burst(1'b0, 4'd4, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
